// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared state encoding and threshold multipliers for the Morse timing path
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    // Thresholds in dot units; the top scales them by UNIT_TICKS
    localparam int unsigned DASH_MULT     = 2;
    localparam int unsigned CHAR_GAP_MULT = 2;
    localparam int unsigned WORD_GAP_MULT = 5;

endpackage

// File: rtl/morse_key_sync.sv
// rtl/morse_key_sync.sv - two-flop synchronizer for the asynchronous key level
module morse_key_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/morse_timing_ctrl.sv
// rtl/morse_timing_ctrl.sv - Morse mark/space timer, dot/dash classifier and gap flags; MORSE_GLITCH_FILTER_EN drops short marks
module morse_timing_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_TICKS   = 600000,
    parameter int unsigned GLITCH_TICKS = 50000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic clk_100Mhz,
    input  logic reset,
    input  logic clk_10Mhz,
    input  logic key_in,
    output logic sym_valid,
    output logic sym_dash,
    output logic char_end,
    output logic word_end,
    output logic active
);

    localparam logic [CNT_W-1:0] DASH_TICKS     = CNT_W'(DASH_MULT * UNIT_TICKS);
    localparam logic [CNT_W-1:0] CHAR_GAP_TICKS = CNT_W'(CHAR_GAP_MULT * UNIT_TICKS);
    localparam logic [CNT_W-1:0] WORD_GAP_TICKS = CNT_W'(WORD_GAP_MULT * UNIT_TICKS);
    localparam logic [CNT_W-1:0] GLITCH_CNT     = CNT_W'(GLITCH_TICKS);
`ifdef MORSE_GLITCH_FILTER_EN
    localparam logic GLITCH_EN = 1'b1;
`else
    localparam logic GLITCH_EN = 1'b0;
`endif

    logic             w_key_s;
    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_glitch;
    logic             r_word_sym;
    logic             w_sym_valid_n;
    logic             w_sym_dash_n;
    logic             w_char_n;
    logic             w_word_n;
    logic             r_sym_valid;
    logic             r_sym_dash;
    logic             r_char_end;
    logic             r_word_end;
    logic             r_active;

    morse_key_sync u_key_sync (
        .i_clk   (clk_100Mhz),
        .i_reset (reset),
        .i_d     (key_in),
        .o_q     (w_key_s)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_glitch  = GLITCH_EN && (r_cnt < GLITCH_CNT);

    always_comb begin
        w_state_n     = r_state;
        w_sym_valid_n = 1'b0;
        w_sym_dash_n  = r_sym_dash;
        w_char_n      = 1'b0;
        w_word_n      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_key_s) w_state_n = ST_MARK;
            end
            ST_MARK: begin
                if (!w_key_s) begin
                    if (w_glitch) begin
                        w_state_n = r_word_sym ? ST_SPACE : ST_IDLE;
                    end else begin
                        w_sym_valid_n = 1'b1;
                        w_sym_dash_n  = (r_cnt >= DASH_TICKS) || (r_cnt == '1);
                        w_state_n     = ST_SPACE;
                    end
                end
            end
            ST_SPACE: begin
                // A new press outranks a gap threshold landing on the same cycle
                if (w_key_s) begin
                    w_state_n = ST_MARK;
                end else if (clk_10Mhz && w_cnt_inc == CHAR_GAP_TICKS) begin
                    w_char_n = 1'b1;
                end else if (clk_10Mhz && w_cnt_inc == WORD_GAP_TICKS) begin
                    w_word_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_word_sym  <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_dash  <= 1'b0;
            r_char_end  <= 1'b0;
            r_word_end  <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sym_valid <= w_sym_valid_n;
            r_sym_dash  <= w_sym_dash_n;
            r_char_end  <= w_char_n;
            r_word_end  <= w_word_n;
            r_active    <= (w_state_n != ST_IDLE);
            if (w_state_n != r_state || r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (clk_10Mhz) begin
                r_cnt <= w_cnt_inc;
            end
            // Remembers whether the current word already produced a symbol
            if (w_state_n == ST_IDLE) begin
                r_word_sym <= 1'b0;
            end else if (w_sym_valid_n) begin
                r_word_sym <= 1'b1;
            end
        end
    end

    assign sym_valid = r_sym_valid;
    assign sym_dash  = r_sym_dash;
    assign char_end  = r_char_end;
    assign word_end  = r_word_end;
    assign active    = r_active;

endmodule

// File: tb/tb_morse_timing_ctrl.sv
// tb/tb_morse_timing_ctrl.sv - scoreboard bench for morse_timing_ctrl (UNIT=4, GLITCH=2, CNT_W=8, tick every 10 clocks)
`timescale 1ns/1ps
module tb_morse_timing_ctrl;

    localparam int K_DOT  = 1;
    localparam int K_DASH = 2;
    localparam int K_CHAR = 3;
    localparam int K_WORD = 4;

    typedef struct {
        int kind;
        int gap;
    } evt_t;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic key_in;
    logic sym_valid;
    logic sym_dash;
    logic char_end;
    logic word_end;
    logic active;

    evt_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   gap     = 0;
    int   n_sym   = 0;
    int   ph      = 0;

    morse_timing_ctrl #(
        .UNIT_TICKS   (4),
        .GLITCH_TICKS (2),
        .CNT_W        (8)
    ) dut (
        .clk_100Mhz (clk),
        .reset      (reset),
        .clk_10Mhz  (tick),
        .key_in     (key_in),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .char_end   (char_end),
        .word_end   (word_end),
        .active     (active)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph   = (ph == 9) ? 0 : ph + 1;
            tick = (ph == 9);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int g);
        evt_t e;
        e.kind = kind;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic take_evt(input int kind, input int g);
        evt_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_evt", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", kind, e.kind);
            if (e.gap >= 0) check("evt_gap", g, e.gap);
        end
    endtask

    // gap counts tick cycles seen since the last symbol, before the current cycle
    always @(negedge clk) begin
        if (sym_valid) begin
            take_evt(sym_dash ? K_DASH : K_DOT, -1);
            gap = 0;
            n_sym++;
        end
        if (char_end) take_evt(K_CHAR, gap);
        if (word_end) take_evt(K_WORD, gap);
        if (tick) gap++;
    end

    task automatic press(input int nticks);
        key_in = 1'b1;
        repeat (nticks * 10) @(posedge clk);
        #1 key_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 1000 && active; i++) @(negedge clk);
        check({tag, "_idle"}, active, 0);
        repeat (3) @(negedge clk);
        check({tag, "_missing"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sym_valid"}, sym_valid, 0);
        check({tag, "_sym_dash"}, sym_dash, 0);
        check({tag, "_char_end"}, char_end, 0);
        check({tag, "_word_end"}, word_end, 0);
        check({tag, "_active"}, active, 0);
    endtask

    initial begin
        int i;
        int base;
        reset  = 1'b1;
        key_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        // Short mark then full word gap
        push(K_DOT, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(3);
        wait_idle("dot_word");

        // Dash, short gap, second symbol without char_end
        push(K_DASH, -1);
        press(9);
        repeat (50) @(posedge clk);
        push(K_DOT, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(3);
        wait_idle("dash_gap");
        check("dash_hold_after", sym_dash, 0);

        push(K_DASH, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(9);
        wait_idle("dash_word");
        check("dash_hold", sym_dash, 1);

        // Reset in the middle of a mark
        key_in = 1'b1;
        repeat (35) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_rst");
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_rst_quiet_active", active, 0);
        check("mid_rst_quiet_q", exp_q.size(), 0);

        // Re-press lands on the cycle the gap would reach the char threshold
        base = n_sym;
        push(K_DOT, -1);
        press(3);
        for (i = 0; i < 300 && n_sym == base; i++) @(negedge clk);
        check("collide_sym_seen", int'(n_sym > base), 1);
        for (i = 0; i < 300 && gap < 7; i++) @(negedge clk);
        check("collide_gap7", gap, 7);
        for (i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (ph == 7) break;
        end
        key_in = 1'b1;
        push(K_DOT, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        repeat (30) @(posedge clk);
        #1 key_in = 1'b0;
        wait_idle("collide");

        // Single-tick press
`ifdef MORSE_GLITCH_FILTER_EN
        press(1);
        repeat (50) @(negedge clk);
        check("glitch_active", active, 0);
        check("glitch_q", exp_q.size(), 0);
`else
        push(K_DOT, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(1);
        wait_idle("short");
`endif

        // Long marks: counter must saturate rather than wrap
        push(K_DASH, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(260);
        wait_idle("sat260");

        push(K_DASH, -1);
        push(K_CHAR, 8);
        push(K_WORD, 20);
        press(300);
        wait_idle("sat300");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
